// File: rtl/and_gate_arbiter.sv
// Round-robin front end that shares one registered AND datapath among NUM_REQ
// requesters, tags each operation through the datapath latency and quiesces on en_in.
module and_gate_arbiter #(
    parameter int INPUT_WIDTH = 8,
    parameter int NUM_REQ     = 4,
    parameter int LATENCY     = 1,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                           clock_in,
    input  logic                           reset_n_in,
    input  logic                           en_in,
    input  logic [NUM_REQ-1:0]             req_valid_in,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_a_in,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_b_in,
    output logic [NUM_REQ-1:0]             req_ready_out,
    output logic [INPUT_WIDTH-1:0]         dp_a_out,
    output logic [INPUT_WIDTH-1:0]         dp_b_out,
    input  logic [INPUT_WIDTH:0]           dp_c_in,
    output logic                           rsp_valid_out,
    output logic [ID_W-1:0]                rsp_id_out,
    output logic [INPUT_WIDTH:0]           rsp_data_out,
    output logic                           idle_out
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                       state;
    state_t                       state_next;
    logic [ID_W-1:0]              ptr;
    logic                         grant_en;
    logic                         grant;
    logic [ID_W-1:0]              grant_id;
    logic [ID_W:0]                scan_sum;
    logic [ID_W-1:0]              scan_idx;
    logic [LATENCY-1:0]           tag_valid;
    logic [LATENCY-1:0][ID_W-1:0] tag_id;
    logic                         pipe_empty;

    assign grant_en   = (state == RUN) && en_in;
    assign pipe_empty = ~|tag_valid && !rsp_valid_out;
    assign idle_out   = (state == IDLE);

    // NOTE: every variable driven here gets a default first; any path that leaves one
    // unassigned would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en_in) state_next = RUN;
            RUN:     if (!en_in) state_next = DRAIN;
            DRAIN:   if (en_in) state_next = RUN;
                     else if (pipe_empty) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // First valid requester at or above ptr, wrapping at NUM_REQ.
    always_comb begin
        grant    = 1'b0;
        grant_id = '0;
        scan_sum = '0;
        scan_idx = '0;
        if (grant_en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan_sum = {1'b0, ptr} + (ID_W+1)'(k);
                if (scan_sum >= (ID_W+1)'(NUM_REQ)) scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
                scan_idx = scan_sum[ID_W-1:0];
                if (!grant && req_valid_in[scan_idx]) begin
                    grant    = 1'b1;
                    grant_id = scan_idx;
                end
            end
        end
    end

    always_comb begin
        req_ready_out = '0;
        dp_a_out      = '0;
        dp_b_out      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant && (grant_id == ID_W'(i))) begin
                req_ready_out[i] = 1'b1;
                dp_a_out         = req_a_in[i*INPUT_WIDTH +: INPUT_WIDTH];
                dp_b_out         = req_b_in[i*INPUT_WIDTH +: INPUT_WIDTH];
            end
        end
    end

    // NOTE: non-blocking assignments in clocked blocks, so every register samples
    // the values that were present before the edge.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_next;
            if (grant) ptr <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
        end
    end

    // NOTE: the tag pipe is reset even though it is storage: its valid bits decide
    // which datapath results respond, so stale tags would leak responses across reset.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            tag_valid <= '0;
            tag_id    <= '0;
        end else begin
            tag_valid[0] <= grant;
            tag_id[0]    <= grant_id;
            for (int i = 1; i < LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            rsp_valid_out <= 1'b0;
            rsp_id_out    <= '0;
            rsp_data_out  <= '0;
        end else begin
            rsp_valid_out <= tag_valid[LATENCY-1];
            if (tag_valid[LATENCY-1]) begin
                rsp_id_out   <= tag_id[LATENCY-1];
                rsp_data_out <= dp_c_in;
            end
        end
    end

endmodule

// File: tb/tb_and_gate_arbiter.sv
// Scoreboard bench for and_gate_arbiter: a LATENCY=1 and a LATENCY=3 instance, each
// with a behavioural registered AND datapath; stimulus queues expected responses.
module tb_and_gate_arbiter;

    typedef struct {
        logic [1:0] id;
        logic [8:0] data;
        int         due;
    } exp_t;

    localparam logic [31:0] A1 = 32'h5AAAF00F;
    localparam logic [31:0] B1 = 32'h0FF03CFF;
    localparam logic [31:0] A2 = 32'hC0FF7E81;
    localparam logic [31:0] B2 = 32'hC0663CC3;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    exp_t q1[$];
    exp_t q3[$];

    logic        en1, rv1, idle1;
    logic [3:0]  v1, rdy1;
    logic [31:0] a1, b1;
    logic [7:0]  dpa1, dpb1;
    logic [8:0]  dpc1, rd1;
    logic [1:0]  rid1;

    logic        en3, rv3, idle3;
    logic [3:0]  v3, rdy3;
    logic [31:0] a3, b3;
    logic [7:0]  dpa3, dpb3;
    logic [8:0]  dpc3, rd3;
    logic [1:0]  rid3;
    logic [8:0]  dp3_pipe [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural datapaths: registered AND, zero-extended, LATENCY stages deep.
    always @(posedge clk) dpc1 <= {1'b0, dpa1 & dpb1};
    always @(posedge clk) begin
        dp3_pipe[0] <= {1'b0, dpa3 & dpb3};
        dp3_pipe[1] <= dp3_pipe[0];
        dp3_pipe[2] <= dp3_pipe[1];
    end
    assign dpc3 = dp3_pipe[2];

    and_gate_arbiter #(.INPUT_WIDTH(8), .NUM_REQ(4), .LATENCY(1)) dut1 (
        .clock_in(clk), .reset_n_in(rst_n), .en_in(en1), .req_valid_in(v1),
        .req_a_in(a1), .req_b_in(b1), .req_ready_out(rdy1), .dp_a_out(dpa1),
        .dp_b_out(dpb1), .dp_c_in(dpc1), .rsp_valid_out(rv1), .rsp_id_out(rid1),
        .rsp_data_out(rd1), .idle_out(idle1)
    );

    and_gate_arbiter #(.INPUT_WIDTH(8), .NUM_REQ(4), .LATENCY(3)) dut3 (
        .clock_in(clk), .reset_n_in(rst_n), .en_in(en3), .req_valid_in(v3),
        .req_a_in(a3), .req_b_in(b3), .req_ready_out(rdy3), .dp_a_out(dpa3),
        .dp_b_out(dpb3), .dp_c_in(dpc3), .rsp_valid_out(rv3), .rsp_id_out(rid3),
        .rsp_data_out(rd3), .idle_out(idle3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    function automatic logic [1:0] oh_id(input logic [3:0] oh);
        oh_id = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) oh_id = 2'(i);
    endfunction

    // One cycle of stimulus: drive, check combinational outputs at negedge, queue the
    // hand-computed response if a grant is expected, then advance to posedge+1.
    task automatic drive(input int lat, input logic en, input logic [3:0] v,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] exp_rdy, input logic [8:0] exp_data,
                         input logic exp_idle, input string name);
        exp_t e;
        if (lat == 1) begin en1 = en; v1 = v; a1 = a; b1 = b; end
        else begin en3 = en; v3 = v; a3 = a; b3 = b; end
        @(negedge clk);
        check({name, " ready"}, (lat == 1) ? rdy1 : rdy3, exp_rdy);
        check({name, " idle"}, (lat == 1) ? idle1 : idle3, exp_idle);
        if (exp_rdy == 4'b0000) begin
            check({name, " dp zero"}, (lat == 1) ? {dpa1, dpb1} : {dpa3, dpb3}, 32'h0);
        end else begin
            e.id   = oh_id(exp_rdy);
            e.data = exp_data;
            e.due  = cyc + lat + 1;
            if (lat == 1) q1.push_back(e);
            else q3.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rv1) begin
            if (q1.size() == 0) check("lat1 unexpected rsp_valid", 32'(rv1), 32'h0);
            else begin
                e = q1.pop_front();
                check("lat1 rsp id", 32'(rid1), 32'(e.id));
                check("lat1 rsp data", 32'(rd1), 32'(e.data));
                check("lat1 rsp cycle", cyc, e.due);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rv3) begin
            if (q3.size() == 0) check("lat3 unexpected rsp_valid", 32'(rv3), 32'h0);
            else begin
                e = q3.pop_front();
                check("lat3 rsp id", 32'(rid3), 32'(e.id));
                check("lat3 rsp data", 32'(rd3), 32'(e.data));
                check("lat3 rsp cycle", cyc, e.due);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end, required completion");
        $fatal(1);
    end

    initial begin
        logic [8:0] rr_exp [8];
        rr_exp = '{9'h00F, 9'h030, 9'h0A0, 9'h00A, 9'h081, 9'h03C, 9'h066, 9'h0C0};

        rst_n = 1'b0;
        en1 = 1'b1; v1 = 4'hF; a1 = A1; b1 = B1;
        en3 = 1'b0; v3 = 4'h0; a3 = '0; b3 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ready", 32'(rdy1), 32'h0);
        check("reset dp operands", {dpa1, dpb1}, 32'h0);
        check("reset rsp_valid", 32'(rv1), 32'h0);
        check("reset rsp_id", 32'(rid1), 32'h0);
        check("reset rsp_data", 32'(rd1), 32'h0);
        check("reset idle", 32'(idle1), 32'h1);
        check("reset idle lat3", 32'(idle3), 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // First cycle after release is still IDLE; the grant follows one cycle later.
        drive(1, 1'b1, 4'b0100, 32'h00F00000, 32'h003C0000, 4'b0000, 9'h000, 1'b1, "release");
        drive(1, 1'b1, 4'b0100, 32'h00F00000, 32'h003C0000, 4'b0100, 9'h030, 1'b0, "single r2");
        drive(1, 1'b1, 4'b0010, 32'h00003C00, 32'h00000F00, 4'b0010, 9'h00C, 1'b0, "single r1 ptr3");

        for (int k = 0; k < 6; k++)
            drive(1, 1'b1, 4'b1010, 32'h66FF99FF, 32'h0FFFF0FF,
                  (k % 2 == 0) ? 4'b1000 : 4'b0010, (k % 2 == 0) ? 9'h006 : 9'h090,
                  1'b0, "alt 1/3");

        drive(1, 1'b1, 4'b1000, 32'h77000000, 32'h1E000000, 4'b1000, 9'h016, 1'b0, "single r3");

        for (int k = 0; k < 8; k++)
            drive(1, 1'b1, 4'b1111, (k < 4) ? A1 : A2, (k < 4) ? B1 : B2,
                  4'b0001 << (k % 4), rr_exp[k], 1'b0, "round robin");

        // Two grants, then en_in falls with both in flight.
        drive(1, 1'b1, 4'b1111, A2, B2, 4'b0001, 9'h081, 1'b0, "drain g0");
        drive(1, 1'b1, 4'b1111, A2, B2, 4'b0010, 9'h03C, 1'b0, "drain g1");
        drive(1, 1'b0, 4'b1111, A2, B2, 4'b0000, 9'h000, 1'b0, "en fall");
        drive(1, 1'b0, 4'b1111, A2, B2, 4'b0000, 9'h000, 1'b0, "drain 1");
        drive(1, 1'b0, 4'b1111, A2, B2, 4'b0000, 9'h000, 1'b0, "drain 2");
        drive(1, 1'b0, 4'b0000, A2, B2, 4'b0000, 9'h000, 1'b1, "drained");
        drive(1, 1'b1, 4'b1111, A1, B1, 4'b0000, 9'h000, 1'b1, "reenable");
        drive(1, 1'b1, 4'b1111, A1, B1, 4'b0100, 9'h0A0, 1'b0, "resume ptr2");
        drive(1, 1'b1, 4'b1111, A1, B1, 4'b1000, 9'h00A, 1'b0, "resume ptr3");
        drive(1, 1'b1, 4'b0000, A1, B1, 4'b0000, 9'h000, 1'b0, "gap 1");
        drive(1, 1'b1, 4'b0000, A1, B1, 4'b0000, 9'h000, 1'b0, "gap 2");

        // Grant that reset will discard: no response is queued for it.
        v1 = 4'b0010;
        @(negedge clk);
        check("pre-reset grant ready", 32'(rdy1), 32'h2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("async reset rsp_valid", 32'(rv1), 32'h0);
        check("async reset rsp_id", 32'(rid1), 32'h0);
        check("async reset rsp_data", 32'(rd1), 32'h0);
        check("async reset idle", 32'(idle1), 32'h1);
        check("async reset ready", 32'(rdy1), 32'h0);
        check("async reset dp operands", {dpa1, dpb1}, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1, 1'b1, 4'b1111, A1, B1, 4'b0000, 9'h000, 1'b1, "rerelease");
        drive(1, 1'b1, 4'b1111, A1, B1, 4'b0001, 9'h00F, 1'b0, "post-reset ptr0");
        for (int k = 0; k < 4; k++)
            drive(1, 1'b1, 4'b0000, A1, B1, 4'b0000, 9'h000, 1'b0, "flush lat1");

        // LATENCY=3 instance: back-to-back grants from requester 0.
        drive(3, 1'b1, 4'b0001, 32'hFF, 32'h0, 4'b0000, 9'h000, 1'b1, "lat3 enable");
        for (int k = 0; k < 6; k++)
            drive(3, 1'b1, 4'b0001, 32'h000000FF, 32'(k), 4'b0001, 9'(k), 1'b0, "lat3 stream");
        for (int k = 0; k < 6; k++)
            drive(3, 1'b1, 4'b0000, 32'h0, 32'h0, 4'b0000, 9'h000, 1'b0, "flush lat3");

        check("lat1 responses outstanding", q1.size(), 32'h0);
        check("lat3 responses outstanding", q3.size(), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
